regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised multi-port register file that succeeds the fixed 8x8 register bank.
- Width and depth are configurable. Two asynchronous read ports, one synchronous write port.
- New over the previous generation: optional hardwired-zero register 0, optional write-to-read bypass, and a per-register busy scoreboard with reserve/release semantics and a live busy count.
- Sits between the decode stage (reserve, read selects) and the ALU write-back (cload/cin).

Parameters:
- W, 8, data width in bits.
- AW, 3, address width; depth N = 2**AW.
- ZERO_R0, 0, when 1 register 0 reads as zero, ignores writes and reservations, and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- cload  in  1  write enable.
- csel  in  AW  write address.
- cin  in  W  write data.
- asel  in  AW  read port A address.
- bsel  in  AW  read port B address.
- aout  out  W  read port A data.
- bout  out  W  read port B data.
- rsv  in  1  reserve request: marks register rsel busy (pending producer).
- rsel  in  AW  register to reserve.
- rsv_ok  out  1  combinational; high when rsv is granted this cycle.
- abusy  out  1  register asel has a pending producer.
- bbusy  out  1  register bsel has a pending producer.
- nbusy  out  AW+1  count of busy registers.

Behaviour:
- Reset (rst low, asynchronous): all N data registers = 0, all busy bits = 0, nbusy = 0. Consequently aout = bout = 0, abusy = bbusy = 0, rsv_ok = rsv && (rsel non-zero when ZERO_R0=1).
- Write: on a rising edge with cload=1, reg[csel] <= cin. The write clears busy[csel], whether or not it was set. When ZERO_R0=1 and csel=0, the write has no effect.
- Read: aout = reg[asel] and bout = reg[bsel], combinational, zero-cycle latency. When ZERO_R0=1 and the select is 0, the output is 0.
- Bypass (BYPASS=1): if cload && csel==asel, then aout = cin and abusy = 0 in the same cycle; port B behaves the same with bsel. Bypass never applies to register 0 when ZERO_R0=1. With BYPASS=0, reads return the pre-edge value.
- Reservation:
  - rsv_ok = rsv && !busy[rsel] && !(ZERO_R0 && rsel==0).
  - On a rising edge with rsv_ok=1, busy[rsel] <= 1.
  - A reserve on an already-busy register is refused: rsv_ok=0, no state change.
- Simultaneous reserve and write:
  - Same register, rsel==csel, register not busy: reserve is granted; busy ends 1 and data is updated (the new producer wins).
  - Same register, register already busy: rsv_ok=0 (the decision uses the pre-edge busy bit); the write clears busy; busy ends 0.
  - Different registers: both take effect independently.
- nbusy: registered; nbusy <= nbusy + set - clr, where:
  - set = rsv_ok;
  - clr = cload && busy[csel] && !(set && rsel==csel).
  - Invariant: nbusy equals the popcount of the busy vector. It cannot overflow, since the maximum is N (or N-1 with ZERO_R0=1).
- abusy and bbusy reflect pre-edge busy bits, except where the bypass clears them. A reserve made in cycle t is visible from cycle t+1.
- Reset asserted mid-operation clears everything immediately; any in-flight write or reserve on that edge is lost.

Decomposition:
- Shared package: constant for the default W and AW, a function returning the one-hot decode of an address with enable (the generalisation of the old enable decoder), and the popcount width helper clog2(N)+1.
- Natural sub-module: regfile_rdport (address mux plus zero-register masking plus bypass compare), instantiated twice for ports A and B.
- Busy vector, count and data array stay in the top module.

Test Plan:
- Reset then reads: assert rst=0 mid-cycle after writing reg3=0xA5 -> immediately aout(asel=3)=0x00, nbusy=0, abusy=0.
- Write/read with BYPASS=1: cload=1, csel=5, cin=0x3C, asel=5 -> aout=0x3C in the same cycle; after the edge with cload=0, aout=0x3C. With BYPASS=0, aout=0x00 in the write cycle.
- Scoreboard: rsv rsel=2 -> rsv_ok=1, next cycle abusy(asel=2)=1 and nbusy=1; a second rsv rsel=2 -> rsv_ok=0, nbusy stays 1; write csel=2 cin=0x11 -> next cycle abusy=0, nbusy=0, aout=0x11.
- Simultaneous reserve and write to reg 4:
  - Idle reg 4 -> busy=1, data updated, nbusy +1.
  - Busy reg 4 -> rsv_ok=0, busy=0, nbusy -1.
- ZERO_R0=1: write csel=0 cin=0xFF -> aout(asel=0)=0x00; rsv rsel=0 -> rsv_ok=0; nbusy unchanged.
- Fill: reserve registers 0..7 on consecutive cycles (ZERO_R0=0) -> nbusy reaches 8; write all 8 -> nbusy returns to 0; nbusy matches the popcount of the busy vector every cycle (checked by assertion).

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned DefW  = 8;
  localparam int unsigned DefAW = 3;

  // Widest address the decode helper supports; callers truncate the result to their depth.
  localparam int unsigned MaxAW = 8;
  localparam int unsigned MaxN  = 1 << MaxAW;

  // One-hot decode of addr, all-zero when en is low.
  function automatic logic [MaxN-1:0] decode(input logic [MaxAW-1:0] addr, input logic en);
    logic [MaxN-1:0] oh;
    oh = '0;
    if (en) oh[addr] = 1'b1;
    return oh;
  endfunction

  // Width needed to count 0..n inclusive for a power-of-two n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One asynchronous read port: address mux, hardwired-zero masking and write bypass.
module regfile_rdport #(
  parameter int unsigned W       = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned BYPASS  = 1
) (
  input  logic [(1<<AW)-1:0][W-1:0] regs,
  input  logic [(1<<AW)-1:0]        busy_vec,
  input  logic [AW-1:0]             sel,
  input  logic                      cload,
  input  logic [AW-1:0]             csel,
  input  logic [W-1:0]              cin,
  output logic [W-1:0]              dout,
  output logic                      dbusy
);

  logic is_zero;
  logic hit;

  assign is_zero = (ZERO_R0 != 0) && (sel == '0);
  // Forwarding never targets the hardwired zero register.
  assign hit     = (BYPASS != 0) && cload && (csel == sel) && !is_zero;

  // Select forwarded, masked or stored value and its busy flag.
  always_comb begin
    dout  = regs[sel];
    dbusy = busy_vec[sel];
    if (is_zero) begin
      dout  = '0;
      dbusy = 1'b0;
    end else if (hit) begin
      dout  = cin;
      dbusy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised 2R1W register file with per-register busy scoreboard and live busy count.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned W       = DefW,
  parameter int unsigned AW      = DefAW,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cload,
  input  logic [AW-1:0] csel,
  input  logic [W-1:0]  cin,
  input  logic [AW-1:0] asel,
  input  logic [AW-1:0] bsel,
  output logic [W-1:0]  aout,
  output logic [W-1:0]  bout,
  input  logic          rsv,
  input  logic [AW-1:0] rsel,
  output logic          rsv_ok,
  output logic          abusy,
  output logic          bbusy,
  output logic [AW:0]   nbusy
);

  localparam int unsigned N    = 1 << AW;
  localparam int unsigned CntW = cnt_width(N);

  logic [N-1:0][W-1:0] regs_q;
  logic [N-1:0]        busy_q, busy_d;
  logic [N-1:0]        set_vec, clr_vec;
  logic [CntW-1:0]     nbusy_q, nbusy_d;
  logic                rsv_zero, wr_zero, wr_en, inc, dec;

  assign rsv_zero = (ZERO_R0 != 0) && (rsel == '0);
  assign wr_zero  = (ZERO_R0 != 0) && (csel == '0);
  assign wr_en    = cload && !wr_zero;

  // Grant decision uses the pre-edge busy bit, so a busy register is refused even if written now.
  assign rsv_ok   = rsv && !busy_q[rsel] && !rsv_zero;

  assign set_vec  = N'(decode(MaxAW'(rsel), rsv_ok));
  assign clr_vec  = N'(decode(MaxAW'(csel), wr_en));

  // Count tracks the busy vector incrementally; a granted reserve to the written register wins.
  assign inc = rsv_ok;
  assign dec = cload && busy_q[csel] && !(rsv_ok && (rsel == csel));

  // Next busy vector: writes clear, grants set, set has priority.
  always_comb begin
    busy_d  = (busy_q & ~clr_vec) | set_vec;
    nbusy_d = nbusy_q + CntW'(inc) - CntW'(dec);
  end

  // Data array write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (clr_vec[i]) regs_q[i] <= cin;
      end
    end
  end

  // Scoreboard state and busy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      nbusy_q <= '0;
    end else begin
      busy_q  <= busy_d;
      nbusy_q <= nbusy_d;
    end
  end

  assign nbusy = nbusy_q;

  regfile_rdport #(
    .W       (W),
    .AW      (AW),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS)
  ) u_rd_a (
    .regs     (regs_q),
    .busy_vec (busy_q),
    .sel      (asel),
    .cload    (cload),
    .csel     (csel),
    .cin      (cin),
    .dout     (aout),
    .dbusy    (abusy)
  );

  regfile_rdport #(
    .W       (W),
    .AW      (AW),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS)
  ) u_rd_b (
    .regs     (regs_q),
    .busy_vec (busy_q),
    .sel      (bsel),
    .cload    (cload),
    .csel     (csel),
    .cin      (cin),
    .dout     (bout),
    .dbusy    (bbusy)
  );

endmodule
